// File: rtl/cpu_dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache with one 32-bit word per line.
// Addresses at or above CACHEABLE_LIMIT go straight to the bus; i_flush writes back every dirty line.
module cpu_dcache_wb #(
    parameter int          SIZE            = 10,
    parameter logic [31:0] CACHEABLE_LIMIT = 32'h40000000
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    output logic        o_bus_rw,
    output logic        o_bus_request,
    input  logic        i_bus_ready,
    output logic [31:0] o_bus_address,
    input  logic [31:0] i_bus_rdata,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_wmask,
    input  logic        i_rw,
    input  logic        i_request,
    output logic        o_ready,
    input  logic [31:0] i_address,
    output logic [31:0] o_rdata,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wmask,
    input  logic        i_flush,
    output logic        o_flush_done
);
    localparam int TAG_W = 30 - SIZE;
    localparam int LINES = 2 ** SIZE;
    localparam int ENT_W = 32 + TAG_W;

    typedef enum logic [3:0] {
        IDLE, LOOKUP, VICTIM_WB, FILL, UNC_RD, UNC_WR,
        FLUSH_RD, FLUSH_CHK, FLUSH_WB, WAIT_END
    } state_t;

    state_t            state_q, state_d;
    logic [LINES-1:0]  valid_q, valid_d, dirty_q, dirty_d;
    logic [SIZE-1:0]   cnt_q, cnt_d;
    logic              bus_rw_q, bus_rw_d, bus_req_q, bus_req_d;
    logic [31:0]       bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_wmask_q, bus_wmask_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              flush_done_q, flush_done_d;

    logic [ENT_W-1:0]  mem [LINES];
    logic [ENT_W-1:0]  ram_rd_q;
    logic              ram_we;
    logic [SIZE-1:0]   ram_addr;
    logic [ENT_W-1:0]  ram_wdata;

    logic [TAG_W-1:0]  req_tag, line_tag;
    logic [SIZE-1:0]   req_idx;
    logic [31:0]       line_data;
    logic              cacheable, hit, full_store, in_flush;
    logic              clean_miss, flush_next;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] mask);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[b*8 +: 8] = mask[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
        return r;
    endfunction

    assign req_tag    = i_address[31:SIZE+2];
    assign req_idx    = i_address[SIZE+1:2];
    assign {line_data, line_tag} = ram_rd_q;
    assign cacheable  = i_address < CACHEABLE_LIMIT;
    assign hit        = valid_q[req_idx] && (line_tag == req_tag);
    assign full_store = i_rw && (i_wmask == 4'hF);
    assign in_flush   = (state_q == FLUSH_RD) || (state_q == FLUSH_CHK) || (state_q == FLUSH_WB);
    assign ram_addr   = in_flush ? cnt_q : req_idx;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        cnt_d        = cnt_q;
        bus_rw_d     = bus_rw_q;
        bus_req_d    = bus_req_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_wmask_d  = bus_wmask_q;
        rdata_d      = rdata_q;
        flush_done_d = 1'b0;
        ram_we       = 1'b0;
        ram_wdata    = {i_wdata, req_tag};
        clean_miss   = 1'b0;
        flush_next   = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_request && !cacheable) begin
                    bus_req_d   = 1'b1;
                    bus_rw_d    = i_rw;
                    bus_addr_d  = {i_address[31:2], 2'b00};
                    bus_wdata_d = i_wdata;
                    bus_wmask_d = i_wmask;
                    state_d     = i_rw ? UNC_WR : UNC_RD;
                end else if (i_request) begin
                    state_d = LOOKUP;
                end else if (i_flush) begin
                    cnt_d   = '0;
                    state_d = FLUSH_RD;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    if (i_rw) begin
                        ram_we           = 1'b1;
                        ram_wdata        = {merge(line_data, i_wdata, i_wmask), req_tag};
                        dirty_d[req_idx] = 1'b1;
                    end else begin
                        rdata_d = line_data;
                    end
                    state_d = WAIT_END;
                end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
                    bus_req_d   = 1'b1;
                    bus_rw_d    = 1'b1;
                    bus_addr_d  = {line_tag, req_idx, 2'b00};
                    bus_wdata_d = line_data;
                    bus_wmask_d = 4'hF;
                    state_d     = VICTIM_WB;
                end else begin
                    clean_miss = 1'b1;
                end
            end
            VICTIM_WB: begin
                if (i_bus_ready) begin
                    dirty_d[req_idx] = 1'b0;
                    clean_miss       = 1'b1;
                end
            end
            FILL: begin
                if (i_bus_ready) begin
                    bus_req_d        = 1'b0;
                    ram_we           = 1'b1;
                    valid_d[req_idx] = 1'b1;
                    if (i_rw) begin
                        ram_wdata        = {merge(i_bus_rdata, i_wdata, i_wmask), req_tag};
                        dirty_d[req_idx] = 1'b1;
                    end else begin
                        ram_wdata        = {i_bus_rdata, req_tag};
                        rdata_d          = i_bus_rdata;
                        dirty_d[req_idx] = 1'b0;
                    end
                    state_d = WAIT_END;
                end
            end
            UNC_RD, UNC_WR: begin
                if (i_bus_ready) begin
                    bus_req_d = 1'b0;
                    if (state_q == UNC_RD) rdata_d = i_bus_rdata;
                    state_d = WAIT_END;
                end
            end
            FLUSH_RD: state_d = FLUSH_CHK;
            FLUSH_CHK: begin
                if (valid_q[cnt_q] && dirty_q[cnt_q]) begin
                    bus_req_d   = 1'b1;
                    bus_rw_d    = 1'b1;
                    bus_addr_d  = {line_tag, cnt_q, 2'b00};
                    bus_wdata_d = line_data;
                    bus_wmask_d = 4'hF;
                    state_d     = FLUSH_WB;
                end else begin
                    flush_next = 1'b1;
                end
            end
            FLUSH_WB: begin
                if (i_bus_ready) begin
                    bus_req_d  = 1'b0;
                    flush_next = 1'b1;
                end
            end
            WAIT_END: if (!i_request) state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        // A full-word store needs nothing from memory, so it allocates without a fill.
        if (clean_miss) begin
            if (full_store) begin
                bus_req_d        = 1'b0;
                ram_we           = 1'b1;
                ram_wdata        = {i_wdata, req_tag};
                valid_d[req_idx] = 1'b1;
                dirty_d[req_idx] = 1'b1;
                state_d          = WAIT_END;
            end else begin
                bus_req_d   = 1'b1;
                bus_rw_d    = 1'b0;
                bus_addr_d  = {i_address[31:2], 2'b00};
                bus_wmask_d = 4'hF;
                state_d     = FILL;
            end
        end

        if (flush_next) begin
            valid_d[cnt_q] = 1'b0;
            dirty_d[cnt_q] = 1'b0;
            if (cnt_q == {SIZE{1'b1}}) begin
                flush_done_d = 1'b1;
                state_d      = IDLE;
            end else begin
                cnt_d   = cnt_q + 1'b1;
                state_d = FLUSH_RD;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            cnt_q        <= '0;
            bus_rw_q     <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_wmask_q  <= '0;
            rdata_q      <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            cnt_q        <= cnt_d;
            bus_rw_q     <= bus_rw_d;
            bus_req_q    <= bus_req_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_wmask_q  <= bus_wmask_d;
            rdata_q      <= rdata_d;
            flush_done_q <= flush_done_d;
        end
    end

    // Data/tag store is not reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge i_clock) begin
        if (ram_we && i_reset_n) mem[ram_addr] <= ram_wdata;
        ram_rd_q <= mem[ram_addr];
    end

    assign o_bus_rw      = bus_rw_q;
    assign o_bus_request = bus_req_q;
    assign o_bus_address = bus_addr_q;
    assign o_bus_wdata   = bus_wdata_q;
    assign o_bus_wmask   = bus_wmask_q;
    assign o_rdata       = rdata_q;
    assign o_flush_done  = flush_done_q;
    assign o_ready       = i_request && (state_q == WAIT_END);

endmodule

// File: tb/tb_cpu_dcache_wb.sv
// Directed bench for cpu_dcache_wb: hits, fills, victim write-back, uncached access, flush, reset mid-transfer.
module tb_cpu_dcache_wb;
    logic        clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        o_bus_rw, o_bus_request, i_bus_ready = 1'b0;
    logic [31:0] o_bus_address, i_bus_rdata = '0, o_bus_wdata;
    logic [3:0]  o_bus_wmask;
    logic        i_rw = 1'b0, i_request = 1'b0, o_ready;
    logic [31:0] i_address = '0, o_rdata, i_wdata = '0;
    logic [3:0]  i_wmask = '0;
    logic        i_flush = 1'b0, o_flush_done;

    int total = 0;
    int bad   = 0;

    logic [31:0] bus_mem [logic [31:0]];
    int          bus_n;
    logic [31:0] lg_addr [8];
    logic [31:0] lg_data [8];
    logic        lg_rw   [8];
    logic [3:0]  lg_mask [8];

    always #5 clk = ~clk;

    cpu_dcache_wb #(.SIZE(10), .CACHEABLE_LIMIT(32'h40000000)) dut (
        .i_clock(clk), .i_reset_n(i_reset_n),
        .o_bus_rw(o_bus_rw), .o_bus_request(o_bus_request), .i_bus_ready(i_bus_ready),
        .o_bus_address(o_bus_address), .i_bus_rdata(i_bus_rdata), .o_bus_wdata(o_bus_wdata),
        .o_bus_wmask(o_bus_wmask), .i_rw(i_rw), .i_request(i_request), .o_ready(o_ready),
        .i_address(i_address), .o_rdata(o_rdata), .i_wdata(i_wdata), .i_wmask(i_wmask),
        .i_flush(i_flush), .o_flush_done(o_flush_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at each negedge: completes any pending bus request in the following clock.
    task automatic bus_step();
        logic [31:0] w;
        i_bus_ready = 1'b0;
        if (o_bus_request) begin
            if (bus_n < 8) begin
                lg_addr[bus_n] = o_bus_address;
                lg_data[bus_n] = o_bus_wdata;
                lg_rw[bus_n]   = o_bus_rw;
                lg_mask[bus_n] = o_bus_wmask;
            end
            bus_n++;
            w = bus_mem.exists(o_bus_address) ? bus_mem[o_bus_address] : 32'h0;
            if (o_bus_rw) begin
                for (int b = 0; b < 4; b++)
                    if (o_bus_wmask[b]) w[b*8 +: 8] = o_bus_wdata[b*8 +: 8];
                bus_mem[o_bus_address] = w;
            end else begin
                i_bus_rdata = w;
            end
            i_bus_ready = 1'b1;
        end
    endtask

    task automatic access(input logic rw, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, output logic [31:0] rd, output int lat);
        bus_n = 0;
        rd    = 'x;
        lat   = -1;
        @(negedge clk);
        i_rw = rw; i_address = a; i_wdata = d; i_wmask = m; i_request = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            bus_step();
            if (o_ready) begin
                rd  = o_rdata;
                lat = c;
                break;
            end
        end
        i_request = 1'b0;
        i_bus_ready = 1'b0;
        chk("access_timeout", 32'(lat >= 0), 32'h1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_reset_n = 1'b0; i_request = 1'b0; i_flush = 1'b0; i_bus_ready = 1'b0;
        repeat (2) @(negedge clk);
        i_reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rd;
        int lat, pulses, seen;

        bus_mem[32'h200]  = 32'hAABBCCDD;
        bus_mem[32'h1100] = 32'h12345678;
        bus_mem[32'h2100] = 32'h0BADF00D;
        bus_mem[32'h20]   = 32'h20202020;

        do_reset();
        chk("rst_bus_request", o_bus_request, 1'b0);
        chk("rst_ready", o_ready, 1'b0);
        chk("rst_flush_done", o_flush_done, 1'b0);
        chk("rst_rdata", o_rdata, 32'h0);
        chk("rst_bus_addr", o_bus_address, 32'h0);

        // full-mask store allocates without bus; load hits in two cycles
        access(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, rd, lat);
        chk("st100_bus", bus_n, 0);
        access(1'b0, 32'h100, 32'h0, 4'h0, rd, lat);
        chk("ld100_lat", lat, 2);
        chk("ld100_data", rd, 32'hDEADBEEF);
        chk("ld100_bus", bus_n, 0);

        // partial store miss fills then merges
        access(1'b1, 32'h200, 32'h11, 4'h1, rd, lat);
        chk("st200_bus_n", bus_n, 1);
        chk("st200_addr", lg_addr[0], 32'h200);
        chk("st200_rw", lg_rw[0], 1'b0);
        chk("st200_mask", lg_mask[0], 4'hF);
        access(1'b0, 32'h200, 32'h0, 4'h0, rd, lat);
        chk("ld200_data", rd, 32'hAABBCC11);
        chk("ld200_bus", bus_n, 0);

        // dirty victim written back before the fill
        access(1'b1, 32'h100, 32'h5, 4'hF, rd, lat);
        chk("st100b_bus", bus_n, 0);
        access(1'b0, 32'h1100, 32'h0, 4'h0, rd, lat);
        chk("vic_bus_n", bus_n, 2);
        chk("vic_wr_addr", lg_addr[0], 32'h100);
        chk("vic_wr_rw", lg_rw[0], 1'b1);
        chk("vic_wr_data", lg_data[0], 32'h5);
        chk("vic_wr_mask", lg_mask[0], 4'hF);
        chk("vic_rd_addr", lg_addr[1], 32'h1100);
        chk("vic_rd_rw", lg_rw[1], 1'b0);
        chk("vic_ld_data", rd, 32'h12345678);
        access(1'b0, 32'h2100, 32'h0, 4'h0, rd, lat);
        chk("clean_vic_bus_n", bus_n, 1);
        chk("clean_vic_addr", lg_addr[0], 32'h2100);
        chk("clean_vic_data", rd, 32'h0BADF00D);

        // uncacheable boundary
        access(1'b1, 32'h40000010, 32'h7, 4'hF, rd, lat);
        chk("unc_st_bus_n", bus_n, 1);
        chk("unc_st_addr", lg_addr[0], 32'h40000010);
        chk("unc_st_rw", lg_rw[0], 1'b1);
        chk("unc_st_mask", lg_mask[0], 4'hF);
        access(1'b0, 32'h40000010, 32'h0, 4'h0, rd, lat);
        chk("unc_ld_bus_n", bus_n, 1);
        chk("unc_ld_data", rd, 32'h7);
        access(1'b1, 32'h3FFFFFFC, 32'hCAFE0001, 4'hF, rd, lat);
        chk("edge_st_bus", bus_n, 0);
        access(1'b0, 32'h3FFFFFFC, 32'h0, 4'h0, rd, lat);
        chk("edge_ld_bus", bus_n, 0);
        chk("edge_ld_data", rd, 32'hCAFE0001);

        // flush: dirty lines 3 and 7, clean valid line 8
        do_reset();
        access(1'b1, 32'hC, 32'h33, 4'hF, rd, lat);
        access(1'b1, 32'h1C, 32'h77, 4'hF, rd, lat);
        access(1'b0, 32'h20, 32'h0, 4'h0, rd, lat);
        bus_n = 0;
        pulses = 0;
        @(negedge clk); i_flush = 1'b1;
        @(negedge clk); i_flush = 1'b0; bus_step();
        for (int c = 0; c < 2400; c++) begin
            @(negedge clk);
            bus_step();
            if (o_flush_done) pulses++;
        end
        chk("flush_bus_n", bus_n, 2);
        chk("flush_wb0_addr", lg_addr[0], 32'hC);
        chk("flush_wb0_data", lg_data[0], 32'h33);
        chk("flush_wb1_addr", lg_addr[1], 32'h1C);
        chk("flush_wb1_data", lg_data[1], 32'h77);
        chk("flush_wb1_rw", lg_rw[1], 1'b1);
        chk("flush_pulses", pulses, 1);
        access(1'b0, 32'hC, 32'h0, 4'h0, rd, lat);
        chk("post_flush_miss", bus_n, 1);
        chk("post_flush_data", rd, 32'h33);
        access(1'b0, 32'h20, 32'h0, 4'h0, rd, lat);
        chk("post_flush_clean_miss", bus_n, 1);

        // reset while a victim write-back is outstanding
        access(1'b1, 32'h10, 32'hAA, 4'hF, rd, lat);
        bus_n = 0;
        seen = 0;
        @(negedge clk);
        i_rw = 1'b0; i_address = 32'h1010; i_wmask = 4'h0; i_request = 1'b1;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge clk);
            if (o_bus_request) seen = 1;
        end
        chk("vwb_req_seen", seen, 1);
        chk("vwb_addr", o_bus_address, 32'h10);
        chk("vwb_rw", o_bus_rw, 1'b1);
        i_reset_n = 1'b0; i_request = 1'b0;
        @(negedge clk);
        chk("vwb_rst_req", o_bus_request, 1'b0);
        chk("vwb_rst_ready", o_ready, 1'b0);
        i_reset_n = 1'b1;
        access(1'b0, 32'h10, 32'h0, 4'h0, rd, lat);
        chk("vwb_old_miss", bus_n, 1);
        chk("vwb_old_addr", lg_addr[0], 32'h10);
        chk("vwb_old_data", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
